double_det: RTL and testbench

- Per-bit double-edge (toggle) detector: flags every rising and falling transition of a level input as a one-clock pulse.
- Sits at the boundary between slow or asynchronous level signals and synchronous control logic.
- Also provides separate rise/fall pulses, an any-edge flag and a wrapping edge-event counter.

---
 rtl/double_det_pkg.sv | 8 +
 rtl/double_det_sync.sv | 33 +++
 rtl/double_det.sv | 84 ++++++++
 tb/tb_double_det.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/double_det_pkg.sv
// Shared defaults and types for the double-edge detector.
package double_det_pkg;
  localparam int DD_WIDTH_DEF       = 1;
  localparam int DD_CNT_W_DEF       = 8;
  localparam int DD_SYNC_STAGES_DEF = 2;

  typedef logic [DD_CNT_W_DEF-1:0] edge_cnt_t;
endpackage

// File: rtl/double_det_sync.sv
// WIDTH x SYNC_STAGES flop-chain synchronizer; only instantiated when DOUBLEDET_SYNC_EN is defined.
module double_det_sync
  import double_det_pkg::*;
#(
  parameter int   WIDTH       = DD_WIDTH_DEF,
  parameter int   SYNC_STAGES = DD_SYNC_STAGES_DEF,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  // Stage 0 captures the raw input; each later stage copies its predecessor.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{{WIDTH{INIT_LEVEL}}}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/double_det.sv
// Per-bit double-edge detector with rise/fall/any pulses and a wrapping edge-event counter.
// Define DOUBLEDET_SYNC_EN to insert a SYNC_STAGES-deep synchronizer ahead of the history registers.
module double_det
  import double_det_pkg::*;
#(
  parameter int   WIDTH       = DD_WIDTH_DEF,
  parameter logic INIT_LEVEL  = 1'b0,
  parameter int   SYNC_STAGES = DD_SYNC_STAGES_DEF,
  parameter int   CNT_W       = DD_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_edge,
  output logic [WIDTH-1:0] d_rise,
  output logic [WIDTH-1:0] d_fall,
  output logic             edge_any,
  output logic [CNT_W-1:0] edge_cnt
);

  logic [WIDTH-1:0] d_in_s;
  logic [WIDTH-1:0] d_r_d, d_r_q;
  logic [WIDTH-1:0] d_rr_d, d_rr_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

`ifdef DOUBLEDET_SYNC_EN
  double_det_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .INIT_LEVEL (INIT_LEVEL)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (d),
    .d_out(d_in_s)
  );
`else
  assign d_in_s = d;
`endif

  always_comb begin
    d_r_d  = d_in_s;
    d_rr_d = d_r_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r_q  <= {WIDTH{INIT_LEVEL}};
      d_rr_q <= {WIDTH{INIT_LEVEL}};
    end else begin
      d_r_q  <= d_r_d;
      d_rr_q <= d_rr_d;
    end
  end

  // Outputs decode the two history registers only, so d never reaches them combinationally.
  assign d_edge   = d_r_q ^ d_rr_q;
  assign d_rise   = d_r_q & ~d_rr_q;
  assign d_fall   = ~d_r_q & d_rr_q;
  assign edge_any = |d_edge;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (edge_any) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign edge_cnt = cnt_q;

endmodule

// File: tb/tb_double_det.sv
// Self-checking bench for double_det: three instances (default, CNT_W=2, WIDTH=4) against a sample-history model.
module tb_double_det;
  import double_det_pkg::*;

`ifdef DOUBLEDET_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic       a_d = 1'b0, a_edge, a_rise, a_fall, a_any;
  edge_cnt_t  a_cnt;
  logic       b_d = 1'b0, b_edge, b_rise, b_fall, b_any;
  logic [1:0] b_cnt;
  logic [3:0] c_d = 4'b0000, c_edge, c_rise, c_fall;
  logic       c_any;
  logic [7:0] c_cnt;

  double_det #(.WIDTH(1), .INIT_LEVEL(1'b0), .SYNC_STAGES(2), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .d(a_d), .d_edge(a_edge), .d_rise(a_rise),
    .d_fall(a_fall), .edge_any(a_any), .edge_cnt(a_cnt));
  double_det #(.WIDTH(1), .INIT_LEVEL(1'b0), .SYNC_STAGES(2), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .clr(clr), .d(b_d), .d_edge(b_edge), .d_rise(b_rise),
    .d_fall(b_fall), .edge_any(b_any), .edge_cnt(b_cnt));
  double_det #(.WIDTH(4), .INIT_LEVEL(1'b0), .SYNC_STAGES(2), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .clr(clr), .d(c_d), .d_edge(c_edge), .d_rise(c_rise),
    .d_fall(c_fall), .edge_any(c_any), .edge_cnt(c_cnt));

  // Packed view: {edge[31:28], rise[27:24], fall[23:20], any[19], 11'b0, cnt[7:0]}
  logic [31:0] act [3];
  assign act[0] = {3'b000, a_edge, 3'b000, a_rise, 3'b000, a_fall, a_any, 11'b0, a_cnt};
  assign act[1] = {3'b000, b_edge, 3'b000, b_rise, 3'b000, b_fall, b_any, 11'b0, 6'b0, b_cnt};
  assign act[2] = {c_edge, c_rise, c_fall, c_any, 11'b0, c_cnt};

  int n_vec = 0;
  int n_mis = 0;

  // Model: every d value sampled since reset release, plus an event count per instance.
  logic [11:0] hist [$];
  int          cnt_m [3];

  function automatic logic [3:0] wmask(int i);
    return (i == 2) ? 4'hF : 4'h1;
  endfunction

  function automatic int cmod(int i);
    return (i == 1) ? 4 : 256;
  endfunction

  function automatic logic [3:0] lvl(int i, int j);
    logic [11:0] w;
    if (j < 0) return 4'h0;
    w = hist[j];
    return w[i*4 +: 4] & wmask(i);
  endfunction

  function automatic logic [31:0] exp_vec(int i);
    int k;
    logic [3:0] cur, prev, e, r, f;
    logic [7:0] c;
    k    = hist.size() - 1;
    cur  = lvl(i, k - LAT);
    prev = lvl(i, k - LAT - 1);
    e    = cur ^ prev;
    r    = cur & ~prev;
    f    = ~cur & prev & wmask(i);
    c    = 8'(cnt_m[i]);
    return {e, r, f, |e, 11'b0, c};
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 3; i++) cnt_m[i] = 0;
  endtask

  // Drive at the current (negedge) time, let one posedge sample it, advance model, return on next negedge.
  task automatic drive_cycle(input logic [11:0] dv, input logic c, input bit glitch);
    logic [31:0] pre;
    a_d = dv[0]; b_d = dv[4]; c_d = dv[11:8]; clr = c;
    if (glitch) begin
      #1; a_d = ~dv[0]; b_d = ~dv[4]; c_d = ~dv[11:8];
      #3; a_d = dv[0];  b_d = dv[4];  c_d = dv[11:8];
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      pre = exp_vec(i);
      if (c) cnt_m[i] = 0;
      else if (pre[19]) cnt_m[i] = (cnt_m[i] + 1) % cmod(i);
    end
    hist.push_back(dv);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (act[i] !== 32'h0) begin
        n_mis++;
        $display("FAIL reset inst%0d t=%0t got %h want %h", i, $time, act[i], 32'h0);
      end
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      drive_cycle(12'h000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (act[i] !== 32'h0) begin
          n_mis++;
          $display("FAIL reset_idle inst%0d t=%0t got %h want %h", i, $time, act[i], 32'h0);
        end
      end
    end
  endtask

  task automatic test_rise_fall();
    logic [11:0] pat [8];
    pat = '{12'h111, 12'h111, 12'h111, 12'h000, 12'h000, 12'h111, 12'h000, 12'h000};
    for (int k = 0; k < 8 + LAT; k++) begin
      drive_cycle((k < 8) ? pat[k] : 12'h000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (act[i] !== exp_vec(i)) begin
          n_mis++;
          $display("FAIL rise_fall inst%0d t=%0t got %h want %h", i, $time, act[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 3 + LAT; k++) begin
      drive_cycle(12'h000, 1'b0, k == 0);
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (act[i] !== exp_vec(i)) begin
          n_mis++;
          $display("FAIL glitch inst%0d t=%0t got %h want %h", i, $time, act[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_wrap_clr();
    logic [11:0] v;
    v = 12'h000;
    for (int k = 0; k < 8 + LAT; k++) begin
      v = v ^ 12'hF11;
      drive_cycle(v, (k == 6 + LAT), 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (act[i] !== exp_vec(i)) begin
          n_mis++;
          $display("FAIL wrap_clr inst%0d t=%0t got %h want %h", i, $time, act[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(12'hA10, 1'b0, 1'b0);
    drive_cycle(12'h501, 1'b0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (act[i] !== 32'h0) begin
        n_mis++;
        $display("FAIL reset_mid inst%0d t=%0t got %h want %h", i, $time, act[i], 32'h0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_init_pattern();
    rst = 1'b1;
    model_reset();
    a_d = 1'b0; b_d = 1'b0; c_d = 4'b1010;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3 + LAT; k++) begin
      drive_cycle(12'hA00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (act[i] !== exp_vec(i)) begin
          n_mis++;
          $display("FAIL init_pattern inst%0d t=%0t got %h want %h", i, $time, act[i], exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive_cycle(12'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (act[i] !== exp_vec(i)) begin
          n_mis++;
          $display("FAIL random inst%0d t=%0t got %h want %h", i, $time, act[i], exp_vec(i));
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rise_fall();
    test_glitch();
    test_wrap_clr();
    test_reset_mid();
    rst = 1'b0;
    test_rise_fall();
    test_init_pattern();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
